// File: rtl/display_scan_mux.sv
// Three-digit 7-segment scan multiplexer with per-frame input snapshots and blanking guard.
// Optional build macro DISPLAY_SCAN_MUX_BRIGHT_EN adds a 2-bit brightness input that shortens the lit window.
module display_scan_mux #(
    parameter int N           = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [6:0]   segA_in,
    input  logic [6:0]   segB_in,
    input  logic [6:0]   segD_in,
    input  logic [N-1:0] aritm_in,
`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
    input  logic [1:0]   bright,
`endif
    output logic [6:0]   seg_out,
    output logic [2:0]   dig_sel,
    output logic [N-1:0] led_out,
    output logic         frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN_A,
        SCAN_B,
        SCAN_D
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic          load;
    logic          restart;
    logic          lit;
    logic [6:0]    snap_a;
    logic [6:0]    snap_b;
    logic [6:0]    snap_d;
    logic [6:0]    cur_a;
    logic [6:0]    cur_b;
    logic [6:0]    cur_d;
    logic [6:0]    nxt_seg;
    logic [2:0]    nxt_dig;

`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
    localparam int SPAN = REFRESH_DIV - GUARD;
    logic [1:0] bright_q;
    logic [1:0] bright_sel;
    int         win;
`endif

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        load      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    nxt_state = SCAN_A;
                    nxt_cnt   = '0;
                    load      = 1'b1;
                end
            end
            default: begin
                if (!en) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end else if (cnt == LAST) begin
                    nxt_cnt = '0;
                    case (state)
                        SCAN_A:  nxt_state = SCAN_B;
                        SCAN_B:  nxt_state = SCAN_D;
                        default: begin
                            nxt_state = SCAN_A;
                            load      = 1'b1;
                            restart   = 1'b1;
                        end
                    endcase
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
        endcase
    end

    // On a snapshot edge the new inputs must feed the output register directly (matters when GUARD = 0).
    always_comb begin
        cur_a = load ? segA_in : snap_a;
        cur_b = load ? segB_in : snap_b;
        cur_d = load ? segD_in : snap_d;
`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
        bright_sel = load ? bright : bright_q;
        win        = SPAN >> (3 - int'(bright_sel));
        lit        = (int'(nxt_cnt) >= GUARD) && (int'(nxt_cnt) < GUARD + win);
`else
        lit        = int'(nxt_cnt) >= GUARD;
`endif
    end

    always_comb begin
        nxt_seg = 7'h7F;
        nxt_dig = 3'b111;
        if (lit) begin
            case (nxt_state)
                SCAN_A: begin
                    nxt_seg = cur_a;
                    nxt_dig = 3'b110;
                end
                SCAN_B: begin
                    nxt_seg = cur_b;
                    nxt_dig = 3'b101;
                end
                SCAN_D: begin
                    nxt_seg = cur_d;
                    nxt_dig = 3'b011;
                end
                default: begin
                    nxt_seg = 7'h7F;
                    nxt_dig = 3'b111;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            snap_a     <= '0;
            snap_b     <= '0;
            snap_d     <= '0;
            seg_out    <= 7'h7F;
            dig_sel    <= 3'b111;
            led_out    <= '0;
            frame_done <= 1'b0;
`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
            bright_q   <= '0;
`endif
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            seg_out    <= nxt_seg;
            dig_sel    <= nxt_dig;
            frame_done <= restart;
            if (load) begin
                snap_a  <= segA_in;
                snap_b  <= segB_in;
                snap_d  <= segD_in;
                led_out <= aritm_in;
`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
                bright_q <= bright;
`endif
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: table-driven frame scan plus disable, mid-scan reset and brightness sequences.
module tb_display_scan_mux;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int G  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [6:0]   seg_a = 7'h7F;
    logic [6:0]   seg_b = 7'h7F;
    logic [6:0]   seg_d = 7'h7F;
    logic [N-1:0] aritm = '0;
    logic [6:0]   seg_out;
    logic [2:0]   dig_sel;
    logic [N-1:0] led_out;
    logic         frame_done;
`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
    logic [1:0]   bright = 2'd3;
`endif

    always #5 clk = ~clk;

    display_scan_mux #(.N(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .segA_in    (seg_a),
        .segB_in    (seg_b),
        .segD_in    (seg_d),
        .aritm_in   (aritm),
`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
        .bright     (bright),
`endif
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .led_out    (led_out),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [6:0]   seg;
        logic [2:0]   dig;
        logic [N-1:0] led;
        logic         fd;
    } exp_t;

    typedef struct {
        logic         r;
        logic         e;
        logic [6:0]   a;
        logic [6:0]   b;
        logic [6:0]   d;
        logic [N-1:0] ar;
        int           reps;
        logic [6:0]   seg;
        logic [2:0]   dig;
        logic [N-1:0] led;
        logic         fd;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [6:0] s, input logic [2:0] dg, input logic [N-1:0] l, input logic f);
        exp_t x;
        x.seg = s;
        x.dig = dg;
        x.led = l;
        x.fd  = f;
        return x;
    endfunction

    // Expected output k edges after the enabling edge, from the slot timing alone.
    function automatic exp_t scan_exp(input int k, input int win, input logic [6:0] a, input logic [6:0] b,
                                      input logic [6:0] d, input logic [N-1:0] l);
        exp_t x;
        int   pos;
        int   slot;
        pos  = k % RD;
        slot = (k / RD) % 3;
        x    = mk(7'h7F, 3'b111, l, (k > 0) && (k % (3 * RD) == 0));
        if (pos >= G && pos < G + win) begin
            case (slot)
                0:       begin x.seg = a; x.dig = 3'b110; end
                1:       begin x.seg = b; x.dig = 3'b101; end
                default: begin x.seg = d; x.dig = 3'b011; end
            endcase
        end
        return x;
    endfunction

    task automatic drive_edge(input string name, input int idx, input logic r, input logic e,
                              input logic [6:0] a, input logic [6:0] b, input logic [6:0] d,
                              input logic [N-1:0] ar, input exp_t ex);
        exp_t want;
        rst   = r;
        en    = e;
        seg_a = a;
        seg_b = b;
        seg_d = d;
        aritm = ar;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        checks++;
        if (seg_out !== want.seg || dig_sel !== want.dig || led_out !== want.led || frame_done !== want.fd) begin
            errors++;
            $display("FAIL %s edge %0d: got seg=%h dig=%b led=%h fd=%b, expected seg=%h dig=%b led=%h fd=%b",
                     name, idx, seg_out, dig_sel, led_out, frame_done, want.seg, want.dig, want.led, want.fd);
        end
    endtask

    initial begin
        int e_idx;
        // Reset rows, then two frames; segB and aritm change at E5 and must not appear until the next frame.
        vt[0]  = '{1'b1, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, 2, 7'h7F, 3'b111, 4'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, 2, 7'h7F, 3'b111, 4'hA, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, 3, 7'h40, 3'b110, 4'hA, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 3, 7'h40, 3'b110, 4'hA, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 2, 7'h7F, 3'b111, 4'hA, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 6, 7'h79, 3'b101, 4'hA, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 2, 7'h7F, 3'b111, 4'hA, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 6, 7'h24, 3'b011, 4'hA, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 1, 7'h7F, 3'b111, 4'h5, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 1, 7'h7F, 3'b111, 4'h5, 1'b0};
        vt[10] = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 6, 7'h40, 3'b110, 4'h5, 1'b0};
        vt[11] = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 2, 7'h7F, 3'b111, 4'h5, 1'b0};
        vt[12] = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 6, 7'h12, 3'b101, 4'h5, 1'b0};
        vt[13] = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 2, 7'h7F, 3'b111, 4'h5, 1'b0};
        vt[14] = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 6, 7'h24, 3'b011, 4'h5, 1'b0};
        vt[15] = '{1'b0, 1'b1, 7'h40, 7'h12, 7'h24, 4'h5, 1, 7'h7F, 3'b111, 4'h5, 1'b1};

        e_idx = -2;
        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < vt[i].reps; j++) begin
                drive_edge("table", e_idx, vt[i].r, vt[i].e, vt[i].a, vt[i].b, vt[i].d, vt[i].ar,
                           mk(vt[i].seg, vt[i].dig, vt[i].led, vt[i].fd));
                e_idx++;
            end
        end

        // Disable mid-slot at E12, stay idle past where frame_done would have been, then re-enable.
        drive_edge("dis_rst", 0, 1'b1, 1'b0, 7'h40, 7'h79, 7'h24, 4'hA, mk(7'h7F, 3'b111, 4'h0, 1'b0));
        for (int k = 0; k < 12; k++)
            drive_edge("dis_run", k, 1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, scan_exp(k, RD - G, 7'h40, 7'h79, 7'h24, 4'hA));
        for (int k = 12; k < 41; k++)
            drive_edge("dis_idle", k, 1'b0, 1'b0, 7'h06, 7'h5B, 7'h4F, 4'h3, mk(7'h7F, 3'b111, 4'hA, 1'b0));
        for (int k = 0; k < 26; k++)
            drive_edge("reen", k, 1'b0, 1'b1, 7'h06, 7'h5B, 7'h4F, 4'h3, scan_exp(k, RD - G, 7'h06, 7'h5B, 7'h4F, 4'h3));

        // Reset while the D digit is lit; en stays high so the scan restarts at A.
        drive_edge("mrst_pre", 0, 1'b1, 1'b0, 7'h40, 7'h79, 7'h24, 4'hA, mk(7'h7F, 3'b111, 4'h0, 1'b0));
        for (int k = 0; k < 20; k++)
            drive_edge("mrst_run", k, 1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, scan_exp(k, RD - G, 7'h40, 7'h79, 7'h24, 4'hA));
        drive_edge("mrst_hit", 20, 1'b1, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, mk(7'h7F, 3'b111, 4'h0, 1'b0));
        for (int k = 0; k < 12; k++)
            drive_edge("mrst_post", k, 1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hC, scan_exp(k, RD - G, 7'h40, 7'h79, 7'h24, 4'hC));

`ifdef DISPLAY_SCAN_MUX_BRIGHT_EN
        bright = 2'd1;
        drive_edge("b1_rst", 0, 1'b1, 1'b0, 7'h40, 7'h79, 7'h24, 4'hA, mk(7'h7F, 3'b111, 4'h0, 1'b0));
        for (int k = 0; k < 50; k++)
            drive_edge("bright1", k, 1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, scan_exp(k, 1, 7'h40, 7'h79, 7'h24, 4'hA));
        bright = 2'd0;
        drive_edge("b0_rst", 0, 1'b1, 1'b0, 7'h40, 7'h79, 7'h24, 4'hA, mk(7'h7F, 3'b111, 4'h0, 1'b0));
        for (int k = 0; k < 50; k++)
            drive_edge("bright0", k, 1'b0, 1'b1, 7'h40, 7'h79, 7'h24, 4'hA, scan_exp(k, 0, 7'h40, 7'h79, 7'h24, 4'hA));
        bright = 2'd3;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
